// File: rtl/scene_renderer.sv
// Full-frame background painter: scans every pixel of the selected scene ROM and plots it through vga_adapter.
// Plot lags the ROM address by ROM_LATENCY cycles; no backpressure, so scene changes mid-frame are queued as a pending repaint.
module scene_renderer #(
    parameter int X_MAX        = 160,
    parameter int Y_MAX        = 120,
    parameter int ROM_LATENCY  = 1,
    parameter int LOC_WIDTH    = 5,
    parameter int COLOUR_WIDTH = 9,
    parameter logic [LOC_WIDTH-1:0] ROOT_LOC = '0
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic [LOC_WIDTH-1:0]    i_location,
    input  logic                    i_redraw,
    output logic [14:0]             o_rom_addr,
    output logic [LOC_WIDTH-1:0]    o_rom_sel,
    input  logic [COLOUR_WIDTH-1:0] i_rom_q,
    output logic [7:0]              o_x,
    output logic [6:0]              o_y,
    output logic [COLOUR_WIDTH-1:0] o_colour,
    output logic                    o_plot,
    output logic                    o_busy,
    output logic                    o_frame_done
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_sx;
    logic [6:0]             r_sy;
    logic [14:0]            r_addr;
    logic [1:0]             r_flush_cnt;
    logic [LOC_WIDTH-1:0]   r_sel;
    logic [LOC_WIDTH-1:0]   r_drawn;
    logic                   r_pending;
    logic [7:0]             r_px [ROM_LATENCY];
    logic [6:0]             r_py [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] r_pv;
    logic                   w_trigger;
    logic                   w_last_px;
    logic                   w_start;
    logic                   w_scan;

    assign w_trigger = (i_location != ROOT_LOC) &&
                       ((i_location != r_drawn) || i_redraw || r_pending);
    assign w_last_px = (r_sx == 8'(X_MAX - 1)) && (r_sy == 7'(Y_MAX - 1));
    assign w_start   = (w_next == S_SCAN) && (r_state != S_SCAN);
    assign w_scan    = (r_state == S_SCAN);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // DONE may chain straight into the next frame so a queued scene starts without an idle gap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next = S_SCAN;
            S_SCAN:  if (w_last_px) w_next = S_FLUSH;
            S_FLUSH: if (r_flush_cnt == 2'(ROM_LATENCY - 1)) w_next = S_DONE;
            S_DONE:  w_next = w_trigger ? S_SCAN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_frame_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sx        <= '0;
            r_sy        <= '0;
            r_addr      <= '0;
            r_flush_cnt <= '0;
            r_sel       <= '0;
            r_drawn     <= ROOT_LOC;
            r_pending   <= 1'b0;
        end else begin
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
            if (w_start) begin
                r_sx      <= '0;
                r_sy      <= '0;
                r_addr    <= '0;
                r_sel     <= i_location;
                r_drawn   <= i_location;
                r_pending <= 1'b0;
            end else begin
                if (w_scan && !w_last_px) begin
                    r_addr <= r_addr + 15'd1;
                    if (r_sx == 8'(X_MAX - 1)) begin
                        r_sx <= '0;
                        r_sy <= r_sy + 7'd1;
                    end else begin
                        r_sx <= r_sx + 8'd1;
                    end
                end
                if (w_next == S_IDLE) r_addr <= '0;
                if ((r_state == S_SCAN || r_state == S_FLUSH) &&
                    ((i_location != r_drawn) || i_redraw))
                    r_pending <= 1'b1;
                else if ((r_state == S_IDLE || r_state == S_DONE) && (i_location == ROOT_LOC))
                    r_pending <= 1'b0;
            end
        end
    end

    // Coordinates only advance with a valid beat, so x/y hold the last plotted pixel.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_pv <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_scan;
            if (w_scan) begin
                r_px[0] <= r_sx;
                r_py[0] <= r_sy;
            end
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_px[i] <= r_px[i-1];
                    r_py[i] <= r_py[i-1];
                end
            end
        end
    end

    assign o_rom_addr = r_addr;
    assign o_rom_sel  = r_sel;
    assign o_x        = r_px[ROM_LATENCY-1];
    assign o_y        = r_py[ROM_LATENCY-1];
    assign o_plot     = r_pv[ROM_LATENCY-1];
    assign o_colour   = i_rom_q;
endmodule

// File: tb/tb_scene_renderer.sv
// Bench for scene_renderer: two instances (ROM latency 1 and 2) share stimulus; a frame-offset model predicts every output.
module tb_scene_renderer;
    localparam int NPIX = 19200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic [4:0] loc;
    logic       redraw;

    logic [14:0] w_addr [2];
    logic [4:0]  w_sel  [2];
    logic [8:0]  w_q    [2];
    logic [7:0]  w_x    [2];
    logic [6:0]  w_y    [2];
    logic [8:0]  w_col  [2];
    logic        w_plot [2];
    logic        w_busy [2];
    logic        w_done [2];

    scene_renderer #(.ROM_LATENCY(1)) u_dut0 (
        .i_clk(clk), .i_resetn(resetn), .i_location(loc), .i_redraw(redraw),
        .o_rom_addr(w_addr[0]), .o_rom_sel(w_sel[0]), .i_rom_q(w_q[0]),
        .o_x(w_x[0]), .o_y(w_y[0]), .o_colour(w_col[0]), .o_plot(w_plot[0]),
        .o_busy(w_busy[0]), .o_frame_done(w_done[0]));

    scene_renderer #(.ROM_LATENCY(2)) u_dut1 (
        .i_clk(clk), .i_resetn(resetn), .i_location(loc), .i_redraw(redraw),
        .o_rom_addr(w_addr[1]), .o_rom_sel(w_sel[1]), .i_rom_q(w_q[1]),
        .o_x(w_x[1]), .o_y(w_y[1]), .o_colour(w_col[1]), .o_plot(w_plot[1]),
        .o_busy(w_busy[1]), .o_frame_done(w_done[1]));

    // Stub ROMs return the low address bits after 1 and 2 cycles.
    logic [14:0] rom0, rom1a, rom1b;
    always @(posedge clk) begin
        rom0  <= w_addr[0];
        rom1a <= w_addr[1];
        rom1b <= rom1a;
    end
    assign w_q[0] = rom0[8:0];
    assign w_q[1] = rom1b[8:0];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each frame is an offset t from SCAN entry; everything follows from t and the latency.
    int         mt     [2];
    bit         mact   [2];
    logic [4:0] msel   [2];
    logic [4:0] mdrawn [2];
    bit         mpend  [2];
    int         mx     [2];
    int         my     [2];
    bit         prev_plot [2];
    int         prev_x [2];
    int         prev_y [2];
    int         prev_addr [2];
    int         run    [2];

    task automatic check_dut(input int d);
        int L;
        int ea;
        bit ep;
        bit ed;
        logic [37:0] act;
        logic [37:0] exp;
        L  = d + 1;
        ep = mact[d] && mt[d] >= L && mt[d] < NPIX + L;
        ed = mact[d] && mt[d] == NPIX + L;
        ea = !mact[d] ? 0 : (mt[d] < NPIX ? mt[d] : NPIX - 1);
        if (ep) begin
            mx[d] = (mt[d] - L) % 160;
            my[d] = (mt[d] - L) / 160;
        end
        act = {w_busy[d], w_done[d], w_plot[d], w_sel[d], w_addr[d], w_x[d], w_y[d]};
        exp = {mact[d], ed, ep, msel[d], 15'(ea), 8'(mx[d]), 7'(my[d])};
        chk($sformatf("dut%0d outputs {busy,done,plot,sel,addr,x,y}", d), act, exp);
        if (ep && w_plot[d])
            chk($sformatf("dut%0d colour", d), w_col[d], (mx[d] + 160 * my[d]) % 512);
        if (w_plot[d] && w_x[d] == 0 && w_y[d] == 1)
            chk($sformatf("dut%0d row_wrap prev {plot,x,y}", d),
                {prev_plot[d], 8'(prev_x[d]), 7'(prev_y[d])}, {1'b1, 8'd159, 7'd0});
        if (w_addr[d] == 15'd160)
            chk($sformatf("dut%0d addr_step prev", d), prev_addr[d], 159);
        if (w_done[d]) begin
            chk($sformatf("dut%0d last_px {plot,x,y}", d),
                {prev_plot[d], 8'(prev_x[d]), 7'(prev_y[d])}, {1'b1, 8'd159, 7'd119});
            chk($sformatf("dut%0d done_addr", d), w_addr[d], 19199);
        end
        if (prev_plot[d] && !w_plot[d])
            chk($sformatf("dut%0d run_len", d), run[d], NPIX);
        run[d]       = w_plot[d] ? run[d] + 1 : 0;
        prev_plot[d] = w_plot[d];
        prev_x[d]    = w_x[d];
        prev_y[d]    = w_y[d];
        prev_addr[d] = w_addr[d];
    endtask

    task automatic step_model(input int d);
        int F;
        F = NPIX + d + 1;
        if (!resetn) begin
            mact[d] = 0; mt[d] = 0; msel[d] = 0; mdrawn[d] = 0; mpend[d] = 0;
            mx[d] = 0; my[d] = 0; prev_plot[d] = 0; run[d] = 0;
        end else if (mact[d] && mt[d] < F) begin
            if (loc != mdrawn[d] || redraw) mpend[d] = 1;
            mt[d]++;
        end else if (loc != 0 && (loc != mdrawn[d] || redraw || mpend[d])) begin
            mact[d] = 1; mt[d] = 0; msel[d] = loc; mdrawn[d] = loc; mpend[d] = 0;
        end else begin
            mact[d] = 0;
            if (loc == 0) mpend[d] = 0;
        end
    endtask

    bit mvalid = 0;
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mvalid) check_dut(d);
                step_model(d);
            end
            if (!resetn) mvalid = 1;
        end
    end

    task automatic wait_done(input int d, input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (w_done[d]) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no frame_done within %0d cycles", nm, lim);
        end
    endtask

    task automatic wait_plot(input int d, input int lim, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (w_plot[d]) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no plot within %0d cycles", nm, lim);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        resetn = 0; loc = 0; redraw = 0;
        tick(3);
        resetn = 1;
        @(negedge clk);
        chk("rst_busy", w_busy[0], 0);
        chk("rst_plot", w_plot[0], 0);
        chk("rst_addr", w_addr[0], 0);
        chk("rst_xy", {w_x[0], w_y[0]}, 0);
        chk("rst_done", w_done[0], 0);

        // Frame A: scene 1; switch to scene 2 around pixel 5000.
        tick(1); loc = 1;
        @(negedge clk); chk("idle_before_edge", w_busy[0], 0);
        @(negedge clk);
        chk("entry_busy", w_busy[0], 1);
        chk("entry_addr", w_addr[0], 0);
        chk("entry_plot", w_plot[0], 0);
        @(negedge clk);
        chk("first_plot", w_plot[0], 1);
        chk("first_xy", {w_x[0], w_y[0]}, 0);
        chk("first_col", w_col[0], 0);
        chk("lat2_not_yet", w_plot[1], 0);
        @(negedge clk);
        chk("lat2_first_plot", w_plot[1], 1);
        chk("lat2_first_xy", {w_x[1], w_y[1]}, 0);
        chk("lat1_second_x", w_x[0], 1);
        tick(4995); loc = 2;
        wait_done(0, 20000, "frame_a_done");
        chk("frame_a_sel", w_sel[0], 1);
        @(negedge clk);
        chk("frame_b_sel", w_sel[0], 2);
        chk("frame_b_busy", w_busy[0], 1);
        chk("frame_b_addr", w_addr[0], 0);
        chk("lat2_a_done", w_done[1], 1);
        chk("lat2_a_sel", w_sel[1], 1);

        // Frame B: two redraw pulses -> exactly one extra frame C.
        tick(3000); redraw = 1;
        tick(1);    redraw = 0;
        tick(2000); redraw = 1;
        tick(1);    redraw = 0;
        wait_done(0, 20000, "frame_b_done");
        @(negedge clk);
        chk("extra_busy", w_busy[0], 1);
        chk("extra_addr", w_addr[0], 0);
        chk("extra_sel", w_sel[0], 2);
        tick(1000); loc = 0;
        wait_done(0, 20000, "frame_c_done");
        @(negedge clk);
        chk("root_idle", w_busy[0], 0);
        repeat (20) @(negedge clk);
        chk("root_still_idle", {w_busy[0], w_busy[1]}, 0);
        chk("root_addr", w_addr[0], 0);
        chk("root_hold_xy", {w_x[0], w_y[0]}, {8'd159, 7'd119});

        // Frame D abandoned by reset near pixel 100, then a fresh frame.
        tick(1); loc = 1;
        tick(101); resetn = 0;
        tick(1);   resetn = 1;
        @(negedge clk);
        chk("mid_rst_plot", {w_plot[0], w_plot[1]}, 0);
        chk("mid_rst_busy", {w_busy[0], w_busy[1]}, 0);
        wait_plot(0, 10, "fresh_frame_plot");
        chk("fresh_xy", {w_x[0], w_y[0]}, 0);
        chk("fresh_sel", w_sel[0], 1);
        repeat (300) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
